mem_stage_ctrl: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register.
- Takes the EX/MEM fields, resolves the branch, and runs loads and stores against a data memory over a req/ack handshake that can take several cycles.
- Stalls the upstream pipeline while an access is outstanding, then loads the MEM/WB pipeline register.
- Sits between the EX/MEM register and the writeback stage.

---
 rtl/mem_stage_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage consumer of the EX/MEM register.
// Resolves branches, runs loads/stores over a req/ack data-memory handshake,
// stalls upstream while an access is outstanding and loads MEM/WB.
// Optional access timeout: define MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              inValid,
  input  logic              inWBrw,
  input  logic              inWBmtoreg,
  input  logic              inBranch,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic [31:0]       inAddResult,
  input  logic              inZero,
  input  logic [31:0]       inALUResult,
  input  logic [31:0]       inReadData2,
  input  logic [4:0]        inWriteReg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              Stall,
  output logic              PCSrc,
  output logic [31:0]       BranchTarget,
  output logic              outValid,
  output logic              OutWBrw,
  output logic              OutWBmtoreg,
  output logic [31:0]       outReadData,
  output logic [31:0]       outALUResult,
  output logic [4:0]        outWriteReg,
  output logic              outMemErr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        memop;
  logic        timeout;
  logic        lat_wbrw;
  logic        lat_mtoreg;
  logic [31:0] lat_alu;
  logic [4:0]  lat_wreg;

  assign memop = inValid & (inMemRead | inMemWrite);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          mem_err;

  // Abort fires in the last allowed ACCESS cycle if no ack has arrived.
  assign timeout   = (state == ACCESS) & ~dmem_ack & (cnt == LAST);
  assign outMemErr = mem_err;

  // Count ACCESS cycles without ack; held at zero while idle so entry starts clean.
  always_ff @(posedge Clk) begin
    if (Rst)                   cnt <= '0;
    else if (state == IDLE)    cnt <= '0;
    else if (!dmem_ack)        cnt <= cnt + 1'b1;
  end

  // Error flag set by an aborted access, cleared by the next MEM/WB load.
  always_ff @(posedge Clk) begin
    if (Rst)          mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
    else if ((state == IDLE && !memop) || (state == ACCESS && dmem_ack))
                      mem_err <= 1'b0;
  end
`else
  assign timeout   = 1'b0;
  assign outMemErr = 1'b0;
`endif

  // Hold upstream while an access is being launched or is still waiting.
  assign Stall        = ((state == IDLE) & memop) |
                        ((state == ACCESS) & ~dmem_ack & ~timeout);
  assign PCSrc        = inValid & inBranch & inZero & ~Stall;
  assign BranchTarget = inAddResult;

  // Two-state access FSM with registered memory-port and MEM/WB outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      lat_wbrw     <= 1'b0;
      lat_mtoreg   <= 1'b0;
      lat_alu      <= '0;
      lat_wreg     <= '0;
      outValid     <= 1'b0;
      OutWBrw      <= 1'b0;
      OutWBmtoreg  <= 1'b0;
      outReadData  <= '0;
      outALUResult <= '0;
      outWriteReg  <= '0;
    end else if (state == IDLE) begin
      if (memop) begin
        // Capture everything needed so EX/MEM may change after the ack cycle.
        state      <= ACCESS;
        dmem_req   <= 1'b1;
        dmem_we    <= inMemWrite;
        dmem_addr  <= inALUResult[ADDR_W-1:0];
        dmem_wdata <= inReadData2;
        lat_wbrw   <= inWBrw;
        lat_mtoreg <= inWBmtoreg;
        lat_alu    <= inALUResult;
        lat_wreg   <= inWriteReg;
        outValid   <= 1'b0;
      end else begin
        outValid     <= inValid;
        OutWBrw      <= inWBrw;
        OutWBmtoreg  <= inWBmtoreg;
        outALUResult <= inALUResult;
        outWriteReg  <= inWriteReg;
      end
    end else begin
      if (dmem_ack || timeout) begin
        state        <= IDLE;
        dmem_req     <= 1'b0;
        outValid     <= 1'b1;
        // An aborted access must not write the register file.
        OutWBrw      <= lat_wbrw & ~timeout;
        OutWBmtoreg  <= lat_mtoreg;
        outALUResult <= lat_alu;
        outWriteReg  <= lat_wreg;
        if (dmem_ack && !dmem_we) outReadData <= dmem_rdata;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table, directed multi-cycle sequences,
// and a randomized run against a transaction-level scoreboard.
module tb_mem_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        inValid, inWBrw, inWBmtoreg, inBranch, inMemRead, inMemWrite, inZero;
  logic [31:0] inAddResult, inALUResult, inReadData2;
  logic [4:0]  inWriteReg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        Stall, PCSrc, outValid, OutWBrw, OutWBmtoreg, outMemErr;
  logic [31:0] BranchTarget, outReadData, outALUResult;
  logic [4:0]  outWriteReg;

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .inValid(inValid), .inWBrw(inWBrw), .inWBmtoreg(inWBmtoreg),
    .inBranch(inBranch), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inAddResult(inAddResult), .inZero(inZero), .inALUResult(inALUResult),
    .inReadData2(inReadData2), .inWriteReg(inWriteReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .outValid(outValid), .OutWBrw(OutWBrw), .OutWBmtoreg(OutWBmtoreg),
    .outReadData(outReadData), .outALUResult(outALUResult),
    .outWriteReg(outWriteReg), .outMemErr(outMemErr)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_in();
    inValid = 0; inWBrw = 0; inWBmtoreg = 0; inBranch = 0; inMemRead = 0;
    inMemWrite = 0; inZero = 0; inAddResult = 0; inALUResult = 0;
    inReadData2 = 0; inWriteReg = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] d2, input logic [4:0] wreg,
                        input logic wbrw, input logic mt);
    inValid = 1; inMemRead = rd; inMemWrite = wr; inALUResult = alu;
    inReadData2 = d2; inWriteReg = wreg; inWBrw = wbrw; inWBmtoreg = mt;
    inBranch = 0; inZero = 0;
  endtask

  task automatic new_instr();
    int k;
    clr_in();
    inValid     = ($urandom_range(0, 7) != 0);
    k           = $urandom_range(0, 4);
    inMemRead   = (k == 1) || (k == 3);
    inMemWrite  = (k == 2) || (k == 3);
    inWBrw      = 1'($urandom);
    inWBmtoreg  = 1'($urandom);
    inBranch    = 1'($urandom);
    inZero      = 1'($urandom);
    inAddResult = $urandom;
    inALUResult = $urandom;
    inReadData2 = $urandom;
    inWriteReg  = 5'($urandom);
  endtask

  // Non-memory vectors: inputs then the expected combinational and MEM/WB results.
  typedef struct {
    logic v, wbrw, mt, br, z;
    logic [31:0] addres, alu;
    logic [4:0] wreg;
    logic e_pcsrc, e_ov, e_wbrw, e_mt;
    logic [31:0] e_alu;
    logic [4:0] e_wreg;
  } vec_t;

  typedef struct {
    logic wbrw, mt;
    logic [31:0] alu, rd;
    logic [4:0] wreg;
  } wb_t;

  vec_t vecs[5];
  wb_t  q[$];

  initial begin
    logic [31:0] last_rd;
    int stall_n, lat, stuck;
    logic in_acc, acc;
    wb_t e, g;

    vecs[0] = '{1,1,0,0,0, 32'h0,  32'h42,       5'd5,  0,1,1,0, 32'h42,       5'd5};
    vecs[1] = '{1,0,0,1,1, 32'h80, 32'h0,        5'd0,  1,1,0,0, 32'h0,        5'd0};
    vecs[2] = '{1,0,0,1,0, 32'h80, 32'h11,       5'd1,  0,1,0,0, 32'h11,       5'd1};
    vecs[3] = '{0,1,0,1,1, 32'h84, 32'h77,       5'd3,  0,0,1,0, 32'h77,       5'd3};
    vecs[4] = '{1,1,1,0,1, 32'h90, 32'hFFFFFFFF, 5'd31, 0,1,1,1, 32'hFFFFFFFF, 5'd31};

    // Reset state.
    clr_in();
    Rst = 1;
    tick();
    tick();
    Rst = 0;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_ov", outValid, 0);
    chk("rst_wbrw", OutWBrw, 0);
    chk("rst_rd", outReadData, 0);
    chk("rst_alu", outALUResult, 0);
    chk("rst_err", outMemErr, 0);

    // Table: single-cycle pass-through and branch resolution.
    for (int i = 0; i < 5; i++) begin
      clr_in();
      inValid = vecs[i].v; inWBrw = vecs[i].wbrw; inWBmtoreg = vecs[i].mt;
      inBranch = vecs[i].br; inZero = vecs[i].z; inAddResult = vecs[i].addres;
      inALUResult = vecs[i].alu; inWriteReg = vecs[i].wreg;
      #1;
      chk($sformatf("vec%0d_stall", i), Stall, 0);
      chk($sformatf("vec%0d_pcsrc", i), PCSrc, vecs[i].e_pcsrc);
      chk($sformatf("vec%0d_btgt", i), BranchTarget, vecs[i].addres);
      tick();
      chk($sformatf("vec%0d_ov", i), outValid, vecs[i].e_ov);
      chk($sformatf("vec%0d_wbrw", i), OutWBrw, vecs[i].e_wbrw);
      chk($sformatf("vec%0d_mt", i), OutWBmtoreg, vecs[i].e_mt);
      chk($sformatf("vec%0d_alu", i), outALUResult, vecs[i].e_alu);
      chk($sformatf("vec%0d_wreg", i), outWriteReg, vecs[i].e_wreg);
      chk($sformatf("vec%0d_rd", i), outReadData, 0);
      chk($sformatf("vec%0d_req", i), dmem_req, 0);
    end

    // Load, ack arrives 3 cycles after req rises.
    clr_in();
    set_op(1, 0, 32'h100, 32'h0, 5'd7, 1, 1);
    inBranch = 1; inZero = 1;
    stall_n = 0;
    #1;
    chk("ld_stall0", Stall, 1);
    chk("ld_pcsrc_stalled", PCSrc, 0);
    chk("ld_req0", dmem_req, 0);
    if (Stall) stall_n++;
    tick();
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("ld_req_c%0d", c), dmem_req, 1);
      chk($sformatf("ld_bubble_c%0d", c), outValid, 0);
      if (Stall) stall_n++;
      tick();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", Stall, 0);
    if (Stall) stall_n++;
    tick();
    dmem_ack = 0; clr_in();
    chk("ld_stall_cycles", stall_n, 4);
    chk("ld_ov", outValid, 1);
    chk("ld_rd", outReadData, 32'hDEADBEEF);
    chk("ld_wreg", outWriteReg, 7);
    chk("ld_alu", outALUResult, 32'h100);
    chk("ld_wbrw", OutWBrw, 1);
    chk("ld_req_done", dmem_req, 0);

    // Store then load accepted in the store's ack cycle.
    set_op(0, 1, 32'h200, 32'h12345678, 5'd0, 0, 0);
    tick();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'h12345678);
    tick();
    dmem_ack = 1;
    #1;
    chk("st_stall_ack", Stall, 0);
    tick();
    dmem_ack = 0;
    set_op(1, 0, 32'h300, 32'h0, 5'd9, 1, 1);
    chk("st_ov", outValid, 1);
    chk("st_rd_kept", outReadData, 32'hDEADBEEF);
    chk("st_alu", outALUResult, 32'h200);
    chk("b2b_gap_req", dmem_req, 0);
    #1;
    chk("b2b_stall", Stall, 1);
    tick();
    chk("b2b_req2", dmem_req, 1);
    chk("b2b_addr2", dmem_addr, 32'h300);
    chk("b2b_we2", dmem_we, 0);
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 0; clr_in();
    chk("b2b_ov", outValid, 1);
    chk("b2b_rd", outReadData, 32'hCAFEF00D);
    chk("b2b_wreg", outWriteReg, 9);

    // Reset two cycles into a load, then a stray ack.
    set_op(1, 0, 32'h400, 32'h0, 5'd4, 1, 1);
    tick();
    tick();
    Rst = 1;
    tick();
    Rst = 0; clr_in();
    chk("rma_req", dmem_req, 0);
    chk("rma_ov", outValid, 0);
    chk("rma_rd", outReadData, 0);
    chk("rma_addr", dmem_addr, 0);
    chk("rma_wreg", outWriteReg, 0);
    dmem_ack = 1; dmem_rdata = 32'h5555AAAA;
    #1;
    chk("rma_stall", Stall, 0);
    tick();
    dmem_ack = 0;
    chk("rma_late_req", dmem_req, 0);
    chk("rma_late_ov", outValid, 0);
    chk("rma_late_rd", outReadData, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Load that is never acknowledged: aborted after 4 ACCESS cycles.
    set_op(1, 0, 32'h500, 32'h0, 5'd6, 1, 0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("to_stall_c%0d", c), Stall, 1);
      chk($sformatf("to_req_c%0d", c), dmem_req, 1);
      tick();
    end
    #1;
    chk("to_stall_release", Stall, 0);
    tick();
    clr_in();
    chk("to_req", dmem_req, 0);
    chk("to_ov", outValid, 1);
    chk("to_err", outMemErr, 1);
    chk("to_wbrw", OutWBrw, 0);
    chk("to_wreg", outWriteReg, 6);
    inValid = 1;
    tick();
    chk("to_err_clr", outMemErr, 0);
`endif

    // Randomized run against an in-order writeback scoreboard.
    clr_in();
    Rst = 1;
    tick();
    Rst = 0;
    last_rd = 0;
    in_acc = 0; lat = 0; stuck = 0;
    new_instr();
    for (int cyc = 0; cyc < 600; cyc++) begin
      dmem_ack = 0;
      if (dmem_req) begin
        if (!in_acc) begin
          in_acc = 1;
          lat = $urandom_range(0, 3);
          chk("rnd_addr", dmem_addr, inALUResult);
          chk("rnd_we", dmem_we, inMemWrite);
          if (inMemWrite) chk("rnd_wdata", dmem_wdata, inReadData2);
        end
        if (lat == 0) begin
          dmem_ack = 1; dmem_rdata = $urandom; in_acc = 0;
        end else lat--;
      end
      #1;
      acc = !Stall;
      chk("rnd_pcsrc", PCSrc, inValid & inBranch & inZero & acc);
      chk("rnd_btgt", BranchTarget, inAddResult);
      if (acc && inValid) begin
        if (inMemRead && !inMemWrite) last_rd = dmem_rdata;
        e.wbrw = inWBrw; e.mt = inWBmtoreg; e.alu = inALUResult;
        e.wreg = inWriteReg; e.rd = last_rd;
        q.push_back(e);
      end
      tick();
      dmem_ack = 0;
      if (outValid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_valid", outValid, 0);
        end else begin
          g = q.pop_front();
          chk("rnd_wbrw", OutWBrw, g.wbrw);
          chk("rnd_mt", OutWBmtoreg, g.mt);
          chk("rnd_alu", outALUResult, g.alu);
          chk("rnd_wreg", outWriteReg, g.wreg);
          chk("rnd_rd", outReadData, g.rd);
          chk("rnd_err", outMemErr, 0);
        end
      end
      if (acc) stuck = 0; else stuck++;
      if (stuck > 8) begin
        chk("rnd_stall_bound", stuck, 0);
        break;
      end
      if (acc) new_instr();
    end
    chk("rnd_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
